hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; index width RIDX = clog2(NREG).
REQ-002 SHALL have parameter DEPTH, default 2: number of tracked in-flight stages. Stage 0 is EXE; stage DEPTH-1 is the last stage before WB. SIDX = max(1, clog2(DEPTH)).
REQ-003 SHALL have parameter LD_STAGE, default 1: first stage index at which load data is forwardable. Legal range 0..DEPTH-1.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 id_valid  in  1  decode slot holds a real instruction.
REQ-007 id_rs, id_rt  in  RIDX each  source register indices.
REQ-008 id_rs_used, id_rt_used  in  1 each  source is actually read.
REQ-009 id_wreg, id_m2reg  in  1 each  instruction writes a register / is a load.
REQ-010 id_dest  in  RIDX  destination register index.
REQ-011 flush  in  1  squash the decode-slot instruction this cycle.
REQ-012 stall  out  1  hold PC and IF/ID, combinational.
REQ-013 fwd_a_hit, fwd_b_hit  out  1 each  forward the source operand.
REQ-014 fwd_a_stage, fwd_b_stage  out  SIDX each  stage supplying the forwarded value.
REQ-015 fwd_a_mem, fwd_b_mem  out  1 each  1 selects memory data; 0 selects the ALU result.
REQ-016 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-017 The block SHALL keep a DEPTH-entry shift register; each entry holds {valid, wreg, m2reg, dest}.
REQ-018 On every rising edge:
- entry[k] SHALL take entry[k-1] for k = 1..DEPTH-1.
- entry[0] SHALL take the decode-slot fields when id_valid=1, stall=0 and flush=0.
- Otherwise entry[0] SHALL load a bubble (valid=0).
REQ-019 An entry SHALL match a source when all of the following hold: entry valid=1, wreg=1, dest != 0, dest equals the source index, and the source's _used bit=1.
REQ-020 For each source, only the youngest matching entry (lowest k) SHALL be considered.
REQ-021 A source SHALL be hazardous when its youngest match is a load (m2reg=1) in a stage k < LD_STAGE.
REQ-022 stall SHALL equal id_valid & ~flush & (rs hazardous | rt hazardous), with zero-cycle latency.
REQ-023 When a source's youngest match is not hazardous: fwd_x_hit=1, fwd_x_stage=k, fwd_x_mem=that entry's m2reg.
REQ-024 When a source has no match, fwd_x_hit, fwd_x_stage and fwd_x_mem SHALL all be 0.
REQ-025 While stall=1, all fwd outputs SHALL be 0.
REQ-026 Register 0 SHALL never cause a stall or a forward.
REQ-027 stall_cnt SHALL increment on each rising edge where stall=1 and SHALL hold at 16'hFFFF.
REQ-028 When flush=1 and a hazard exist simultaneously, flush SHALL win: stall=0 and a bubble is inserted.
REQ-029 Writeback is not tracked; the register file writes on the falling edge and supplies WB values directly.

Reset
REQ-030 When rst_n=0, all entry valid bits and stall_cnt SHALL clear immediately, without waiting for a clock edge.
REQ-031 During reset, stall and every fwd output SHALL be 0.
REQ-032 Asserting reset during a stall SHALL drop stall in the same cycle. No stall SHALL persist after rst_n rises.

Configuration
REQ-033 Macro HAZARD_FWD_EN.
REQ-034 When HAZARD_FWD_EN is defined: behaviour is as in REQ-021 to REQ-025.
REQ-035 When HAZARD_FWD_EN is undefined:
- Any match in any tracked stage SHALL be hazardous.
- All fwd outputs SHALL be constant 0.
- No forwarding comparators or priority logic SHALL be synthesized.

Verification
REQ-036 Scenario (FWD_EN): add $3,$1,$2 then sub $4,$9,$3 -> stall=0; fwd_b_hit=1, fwd_b_stage=0, fwd_b_mem=0.
REQ-037 Scenario (no FWD_EN): same sequence as REQ-036 -> stall=1 for exactly 2 cycles; stall_cnt=2.
REQ-038 Scenario (FWD_EN): lw $2,0($1) then add $3,$2,$1 -> stall=1 for 1 cycle; next cycle fwd_a_hit=1, fwd_a_stage=1, fwd_a_mem=1.
REQ-039 Scenario: $5 written by both stage 0 and stage 1, then or $6,$5,$9 -> fwd_a_stage=0, i.e. the youngest entry wins.
REQ-040 Scenario: add $0,$1,$2 then add $3,$0,$0 -> stall=0, no forward. Separately, a load-use hazard with flush=1 -> stall=0 and a bubble enters stage 0.
REQ-041 Scenario: rst_n=0 asserted mid-stall -> stall=0 and stall_cnt=0 at once. Separately, 65540 forced stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: raises load-use stalls and selects forwarding sources for ID operands.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it any in-flight producer stalls decode.
module hazard_scoreboard #(
    parameter int  NREG     = 32,
    parameter int  DEPTH    = 2,
    parameter int  LD_STAGE = 1,
    localparam int RIDX     = $clog2(NREG),
    localparam int SIDX     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RIDX-1:0] id_rs,
    input  logic [RIDX-1:0] id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic [RIDX-1:0] id_dest,
    input  logic            flush,
    output logic            stall,
    output logic            fwd_a_hit,
    output logic            fwd_b_hit,
    output logic [SIDX-1:0] fwd_a_stage,
    output logic [SIDX-1:0] fwd_b_stage,
    output logic            fwd_a_mem,
    output logic            fwd_b_mem,
    output logic [15:0]     stall_cnt
);

    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] wreg_reg, wreg_next;
    logic [DEPTH-1:0] m2reg_reg, m2reg_next;
    logic [RIDX-1:0]  dest_reg  [DEPTH];
    logic [RIDX-1:0]  dest_next [DEPTH];
    logic [15:0]      stall_cnt_reg;

    logic             stall_int;
    logic             issue;
    logic [RIDX-1:0]  src_idx  [2];
    logic             src_used [2];
    logic [DEPTH-1:0] match    [2];
    logic             hazard   [2];

    assign src_idx[0]  = id_rs;
    assign src_idx[1]  = id_rt;
    assign src_used[0] = id_rs_used;
    assign src_used[1] = id_rt_used;

    assign issue = id_valid & ~stall_int & ~flush;

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = issue;
                assign wreg_next[gi]  = id_wreg;
                assign m2reg_next[gi] = id_m2reg;
                assign dest_next[gi]  = id_dest;
            end else begin : g_tail
                assign valid_next[gi] = valid_reg[gi-1];
                assign wreg_next[gi]  = wreg_reg[gi-1];
                assign m2reg_next[gi] = m2reg_reg[gi-1];
                assign dest_next[gi]  = dest_reg[gi-1];
            end

            // Register 0 is hard-wired, so a producer targeting it never counts.
            logic live;
            assign live = valid_reg[gi] & wreg_reg[gi] & (dest_reg[gi] != '0);

            for (gj = 0; gj < 2; gj++) begin : g_src
                assign match[gj][gi] = live & src_used[gj] & (dest_reg[gi] == src_idx[gj]);
            end
        end
    endgenerate

    // Only the valid bits need reset; payload is ignored while its valid bit is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        wreg_reg  <= wreg_next;
        m2reg_reg <= m2reg_next;
        dest_reg  <= dest_next;
    end

`ifdef HAZARD_FWD_EN
    logic            hit       [2];
    logic [SIDX-1:0] hit_stage [2];
    logic            hit_mem   [2];
    logic            fwd_ok    [2];

    // Scan oldest to youngest so the lowest matching stage is the one that sticks.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]       = 1'b0;
            hit_stage[s] = '0;
            hit_mem[s]   = 1'b0;
            hazard[s]    = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[s][k]) begin
                    hit[s]       = 1'b1;
                    hit_stage[s] = SIDX'(k);
                    hit_mem[s]   = m2reg_reg[k];
                    hazard[s]    = m2reg_reg[k] && (k < LD_STAGE);
                end
            end
        end
    end

    assign fwd_ok[0] = hit[0] & ~hazard[0] & ~stall_int;
    assign fwd_ok[1] = hit[1] & ~hazard[1] & ~stall_int;

    assign fwd_a_hit   = fwd_ok[0];
    assign fwd_a_stage = fwd_ok[0] ? hit_stage[0] : '0;
    assign fwd_a_mem   = fwd_ok[0] & hit_mem[0];
    assign fwd_b_hit   = fwd_ok[1];
    assign fwd_b_stage = fwd_ok[1] ? hit_stage[1] : '0;
    assign fwd_b_mem   = fwd_ok[1] & hit_mem[1];
`else
    // Without forwarding, any in-flight producer of a source must drain first.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hazard[s] = |match[s];
        end
    end

    logic unused_fwd;
    assign unused_fwd = ^m2reg_reg;

    assign fwd_a_hit   = 1'b0;
    assign fwd_a_stage = '0;
    assign fwd_a_mem   = 1'b0;
    assign fwd_b_hit   = 1'b0;
    assign fwd_b_stage = '0;
    assign fwd_b_mem   = 1'b0;
`endif

    assign stall_int = rst_n & id_valid & ~flush & (hazard[0] | hazard[1]);
    assign stall     = stall_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall_int && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios, randomized traffic against a
// behavioural model, asynchronous reset and counter saturation (deep instance). Honours HAZARD_FWD_EN.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int NREG     = 32;
    localparam int DEPTH    = 2;
    localparam int LD_STAGE = 1;
    localparam int RIDX     = 5;
    localparam int SIDX     = 1;
    localparam int BDEPTH   = 32;
    localparam int BLD      = 31;
    localparam int BSIDX    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg, flush;
    logic [RIDX-1:0] id_rs, id_rt, id_dest;
    logic            stall, fwd_a_hit, fwd_b_hit, fwd_a_mem, fwd_b_mem;
    logic [SIDX-1:0] fwd_a_stage, fwd_b_stage;
    logic [15:0]     stall_cnt;

    logic             b_id_valid, b_id_rs_used, b_id_rt_used, b_id_wreg, b_id_m2reg, b_flush;
    logic [RIDX-1:0]  b_id_rs, b_id_rt, b_id_dest;
    logic             b_stall, b_fwd_a_hit, b_fwd_b_hit, b_fwd_a_mem, b_fwd_b_mem;
    logic [BSIDX-1:0] b_fwd_a_stage, b_fwd_b_stage;
    logic [15:0]      b_stall_cnt;

    hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .LD_STAGE(LD_STAGE)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_dest(id_dest), .flush(flush), .stall(stall), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_stage(fwd_a_stage), .fwd_b_stage(fwd_b_stage), .fwd_a_mem(fwd_a_mem),
        .fwd_b_mem(fwd_b_mem), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.NREG(NREG), .DEPTH(BDEPTH), .LD_STAGE(BLD)) dut_deep (
        .clk(clk), .rst_n(rst_n), .id_valid(b_id_valid), .id_rs(b_id_rs), .id_rt(b_id_rt),
        .id_rs_used(b_id_rs_used), .id_rt_used(b_id_rt_used), .id_wreg(b_id_wreg), .id_m2reg(b_id_m2reg),
        .id_dest(b_id_dest), .flush(b_flush), .stall(b_stall), .fwd_a_hit(b_fwd_a_hit),
        .fwd_b_hit(b_fwd_b_hit), .fwd_a_stage(b_fwd_a_stage), .fwd_b_stage(b_fwd_b_stage),
        .fwd_a_mem(b_fwd_a_mem), .fwd_b_mem(b_fwd_b_mem), .stall_cnt(b_stall_cnt)
    );

    // Reference model: list of in-flight instructions indexed by age (0 = youngest).
    typedef struct { bit v; bit w; bit m; int d; } ent_t;
    ent_t pipe [DEPTH];
    int   mcnt;
    bit   e_stall;
    bit   e_hit   [2];
    bit   e_mem   [2];
    int   e_stage [2];
    int   errors = 0;
    int   checks = 0;

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) pipe[i] = '{default: 0};
        mcnt = 0;
    endtask

    function automatic void find_youngest(input int src, input bit used,
                                          output bit found, output int k, output bit m);
        found = 1'b0;
        k     = 0;
        m     = 1'b0;
        if (used && src != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && pipe[i].v && pipe[i].w && pipe[i].d == src) begin
                    found = 1'b1;
                    k     = i;
                    m     = pipe[i].m;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        bit f [2];
        int k [2];
        bit m [2];
        bit hz [2];
        find_youngest(int'(id_rs), id_rs_used, f[0], k[0], m[0]);
        find_youngest(int'(id_rt), id_rt_used, f[1], k[1], m[1]);
        for (int s = 0; s < 2; s++) begin
`ifdef HAZARD_FWD_EN
            hz[s] = f[s] && m[s] && (k[s] < LD_STAGE);
`else
            hz[s] = f[s];
`endif
        end
        e_stall = (rst_n === 1'b1) && id_valid && !flush && (hz[0] || hz[1]);
        for (int s = 0; s < 2; s++) begin
            e_hit[s]   = 1'b0;
            e_stage[s] = 0;
            e_mem[s]   = 1'b0;
`ifdef HAZARD_FWD_EN
            if (!e_stall && f[s] && !hz[s]) begin
                e_hit[s]   = 1'b1;
                e_stage[s] = k[s];
                e_mem[s]   = m[s];
            end
`endif
        end
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                         input bit w, input bit m, input int d, input bit fl);
        id_valid   = v;
        id_rs      = RIDX'(rs);
        id_rt      = RIDX'(rt);
        id_rs_used = ru;
        id_rt_used = tu;
        id_wreg    = w;
        id_m2reg   = m;
        id_dest    = RIDX'(d);
        flush      = fl;
        #1;
        model_eval();
    endtask

    task automatic tick();
        $display("cyc t=%0t rst_n=%0d v=%0d rs=%0d rt=%0d wr=%0d ld=%0d dest=%0d flush=%0d -> stall=%0d fa=%0d/%0d/%0d fb=%0d/%0d/%0d cnt=%0d",
                 $time, rst_n, id_valid, id_rs, id_rt, id_wreg, id_m2reg, id_dest, flush, stall,
                 fwd_a_hit, fwd_a_stage, fwd_a_mem, fwd_b_hit, fwd_b_stage, fwd_b_mem, stall_cnt);
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            clear_model();
        end else begin
            if (e_stall && mcnt < 65535) mcnt++;
            for (int i = DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (id_valid && !e_stall && !flush)
                pipe[0] = '{v: 1'b1, w: id_wreg, m: id_m2reg, d: int'(id_dest)};
            else
                pipe[0] = '{default: 0};
        end
        #1;
        model_eval();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 2, 1, 1, 1, 1, 3, 0);
        clear_model();
        model_eval();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        checks++;
        if ({fwd_a_hit, fwd_b_hit, fwd_a_mem, fwd_b_mem} !== 4'b0000 || fwd_a_stage !== SIDX'(0) || fwd_b_stage !== SIDX'(0)) begin
            errors++; $display("FAIL reset_fwd: got hit=%0d%0d mem=%0d%0d expected all 0", fwd_a_hit, fwd_b_hit, fwd_a_mem, fwd_b_mem);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        tick();
        tick();
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_alu_forward();
        idle(DEPTH);
        drive(1, 1, 2, 1, 1, 1, 0, 3, 0);   // add $3,$1,$2
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_first_stall: got %0d expected 0", stall); end
        tick();
        drive(1, 9, 3, 1, 1, 1, 0, 4, 0);   // sub $4,$9,$3
`ifdef HAZARD_FWD_EN
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_fwd_stall: got %0d expected 0", stall); end
        checks++;
        if (fwd_b_hit !== 1'b1 || fwd_b_stage !== SIDX'(0) || fwd_b_mem !== 1'b0 || fwd_a_hit !== 1'b0) begin
            errors++; $display("FAIL alu_fwd_b: got a_hit=%0d b_hit=%0d stage=%0d mem=%0d expected 0 1 0 0", fwd_a_hit, fwd_b_hit, fwd_b_stage, fwd_b_mem);
        end
        tick();
`else
        begin
            int n = 0;
            for (int i = 0; i < 8 && stall === 1'b1; i++) begin
                n++;
                tick();
            end
            checks++;
            if (n != 2) begin errors++; $display("FAIL alu_nofwd_stall_cycles: got %0d expected 2", n); end
            tick();
            checks++;
            if (stall_cnt !== 16'd2) begin errors++; $display("FAIL alu_nofwd_cnt: got %0d expected 2", stall_cnt); end
        end
`endif
    endtask

    task automatic test_load_use();
        idle(DEPTH);
        drive(1, 1, 2, 1, 0, 1, 1, 2, 0);   // lw $2,0($1)
        tick();
        drive(1, 2, 1, 1, 1, 1, 0, 3, 0);   // add $3,$2,$1
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall0: got %0d expected 1", stall); end
        tick();
`ifdef HAZARD_FWD_EN
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_stall1: got %0d expected 0", stall); end
        checks++;
        if (fwd_a_hit !== 1'b1 || fwd_a_stage !== SIDX'(1) || fwd_a_mem !== 1'b1 || fwd_b_hit !== 1'b0) begin
            errors++; $display("FAIL load_use_fwd_a: got hit=%0d stage=%0d mem=%0d b_hit=%0d expected 1 1 1 0", fwd_a_hit, fwd_a_stage, fwd_a_mem, fwd_b_hit);
        end
`else
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall1: got %0d expected 1", stall); end
        tick();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL load_use_stall2: got %0d expected 0", stall); end
`endif
        tick();
    endtask

    task automatic test_youngest();
        idle(DEPTH);
        drive(1, 1, 2, 1, 1, 1, 0, 5, 0);   // add $5,$1,$2
        tick();
        drive(1, 3, 4, 1, 1, 1, 0, 5, 0);   // add $5,$3,$4
        tick();
        drive(1, 5, 9, 1, 1, 1, 0, 6, 0);   // or $6,$5,$9
`ifdef HAZARD_FWD_EN
        checks++;
        if (stall !== 1'b0 || fwd_a_hit !== 1'b1 || fwd_a_stage !== SIDX'(0) || fwd_a_mem !== 1'b0) begin
            errors++; $display("FAIL youngest: got stall=%0d hit=%0d stage=%0d mem=%0d expected 0 1 0 0", stall, fwd_a_hit, fwd_a_stage, fwd_a_mem);
        end
`else
        checks++;
        if (stall !== 1'b1 || fwd_a_hit !== 1'b0) begin
            errors++; $display("FAIL youngest: got stall=%0d hit=%0d expected 1 0", stall, fwd_a_hit);
        end
`endif
        idle(DEPTH + 2);
    endtask

    task automatic test_reg0();
        idle(DEPTH);
        drive(1, 1, 2, 1, 1, 1, 1, 0, 0);   // lw $0,.. producer of register 0
        tick();
        drive(1, 0, 0, 1, 1, 1, 0, 3, 0);   // add $3,$0,$0
        checks++;
        if (stall !== 1'b0 || fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin
            errors++; $display("FAIL reg0: got stall=%0d a_hit=%0d b_hit=%0d expected 0 0 0", stall, fwd_a_hit, fwd_b_hit);
        end
        tick();
    endtask

    task automatic test_flush();
        idle(DEPTH);
        drive(1, 1, 2, 1, 0, 1, 1, 2, 0);   // lw $2,0($1)
        tick();
        drive(1, 2, 1, 1, 1, 1, 0, 3, 1);   // add $3,$2,$1 squashed
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0d expected 0", stall); end
        tick();
        drive(1, 3, 3, 1, 1, 1, 0, 7, 0);   // or $7,$3,$3 must not see the squashed add
        checks++;
        if (stall !== 1'b0 || fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin
            errors++; $display("FAIL flush_bubble: got stall=%0d a_hit=%0d b_hit=%0d expected 0 0 0", stall, fwd_a_hit, fwd_b_hit);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7) == 0);
            checks++;
            if (stall !== e_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, stall, e_stall); end
            checks++;
            if ({fwd_a_hit, fwd_a_stage, fwd_a_mem} !== {e_hit[0], SIDX'(e_stage[0]), e_mem[0]}) begin
                errors++; $display("FAIL rand_fwd_a[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                                   fwd_a_hit, fwd_a_stage, fwd_a_mem, e_hit[0], e_stage[0], e_mem[0]);
            end
            checks++;
            if ({fwd_b_hit, fwd_b_stage, fwd_b_mem} !== {e_hit[1], SIDX'(e_stage[1]), e_mem[1]}) begin
                errors++; $display("FAIL rand_fwd_b[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                                   fwd_b_hit, fwd_b_stage, fwd_b_mem, e_hit[1], e_stage[1], e_mem[1]);
            end
            checks++;
            if (stall_cnt !== 16'(mcnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, stall_cnt, mcnt); end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        idle(DEPTH);
        drive(1, 1, 2, 1, 0, 1, 1, 2, 0);   // lw $2,0($1)
        tick();
        drive(1, 2, 1, 1, 1, 1, 0, 3, 0);   // dependent add stalls in either build
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %0d expected 1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        model_eval();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %0d expected 0", stall); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", stall_cnt); end
        tick();
        rst_n = 1'b1;
        drive(1, 2, 1, 1, 1, 1, 0, 3, 0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midrst_after: got %0d expected 0", stall); end
        tick();
    endtask

    task automatic test_saturation();
        int period;
        int per_stalls;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_id_valid   = 1'b1;   // repeated lw $2,0($2): each one depends on its predecessor
        b_id_rs      = RIDX'(2);
        b_id_rt      = RIDX'(0);
        b_id_rs_used = 1'b1;
        b_id_rt_used = 1'b0;
        b_id_wreg    = 1'b1;
        b_id_m2reg   = 1'b1;
        b_id_dest    = RIDX'(2);
        b_flush      = 1'b0;
`ifdef HAZARD_FWD_EN
        period     = BLD + 1;
        per_stalls = BLD;
`else
        period     = BDEPTH + 1;
        per_stalls = BDEPTH;
`endif
        for (int p = 0; p < 2115; p++) begin
            for (int c = 0; c < period; c++) begin
                if (p == 1 && c == 0) begin
                    checks++;
                    if (b_stall !== 1'b0) begin errors++; $display("FAIL sat_issue_stall: got %0d expected 0", b_stall); end
`ifdef HAZARD_FWD_EN
                    checks++;
                    if (b_fwd_a_hit !== 1'b1 || b_fwd_a_stage !== BSIDX'(BLD) || b_fwd_a_mem !== 1'b1) begin
                        errors++; $display("FAIL sat_deep_fwd: got %0d/%0d/%0d expected 1/%0d/1", b_fwd_a_hit, b_fwd_a_stage, b_fwd_a_mem, BLD);
                    end
`endif
                end
                if (p == 1 && c == 1) begin
                    checks++;
                    if (b_stall !== 1'b1) begin errors++; $display("FAIL sat_dep_stall: got %0d expected 1", b_stall); end
                end
                @(posedge clk);
                #1;
            end
            if (p == 99) begin
                checks++;
                if (b_stall_cnt !== 16'(100 * per_stalls)) begin
                    errors++; $display("FAIL sat_mid_cnt: got %0d expected %0d", b_stall_cnt, 100 * per_stalls);
                end
            end
        end
        checks++;
        if (b_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %0h expected ffff", b_stall_cnt); end
        $display("saturation run: %0d stall cycles issued, stall_cnt=%0h", 2115 * per_stalls, b_stall_cnt);
        b_id_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        id_valid     = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_wreg      = 1'b0; id_m2reg = 1'b0; id_dest = '0; flush = 1'b0;
        b_id_valid   = 1'b0; b_id_rs = '0; b_id_rt = '0; b_id_rs_used = 1'b0; b_id_rt_used = 1'b0;
        b_id_wreg    = 1'b0; b_id_m2reg = 1'b0; b_id_dest = '0; b_flush = 1'b0;
        clear_model();
        #2;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_reg0();
        test_flush();
        test_random(400);
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
